// File: rtl/datapath_fifo_wr_arbiter_if.sv
// rtl/datapath_fifo_wr_arbiter_if.sv - producer and FIFO write-port bundle for the pair-atomic arbiter
interface datapath_fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  req0_valid;
  logic                  req0_last;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic                  req1_last;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  fifo_full;
  logic                  fifo_threshold;
  logic                  fifo_wr;
  logic [DATA_WIDTH-1:0] fifo_data_in;

  modport slave (
    input  req0_valid, req0_last, req0_data,
    input  req1_valid, req1_last, req1_data,
    input  fifo_full, fifo_threshold,
    output req0_ready, req1_ready,
    output fifo_wr, fifo_data_in
  );

  modport master (
    output req0_valid, req0_last, req0_data,
    output req1_valid, req1_last, req1_data,
    output fifo_full, fifo_threshold,
    input  req0_ready, req1_ready,
    input  fifo_wr, fifo_data_in
  );
endinterface

// File: rtl/datapath_fifo_wr_arbiter.sv
// rtl/datapath_fifo_wr_arbiter.sv - pair-atomic two-producer arbiter for the FIFO write port
module datapath_fifo_wr_arbiter #(
  parameter int DATA_WIDTH    = 128,
  parameter int TIMEOUT       = 256,
  parameter int PAD_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  datapath_fifo_wr_arbiter_if.slave   bus,
  output logic [1:0]                  grant,
  output logic                        pad_event,
  output logic [PAD_CNT_WIDTH-1:0]    pad_count,
  output logic                        proto_err
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_PAD} state_t;

  state_t                   r_state;
  logic [1:0]               r_grant;
  logic                     r_ptr;
  logic [TO_W-1:0]          r_to;
  logic [PAD_CNT_WIDTH-1:0] r_pad_cnt;
  logic                     r_perr;
  logic [DATA_WIDTH-1:0]    r_data;

  logic                     w_q0, w_q1, w_pick1;
  logic                     w_g_valid, w_g_last, w_g_rdy;
  logic [DATA_WIDTH-1:0]    w_g_data;
  logic                     w_rdy0, w_rdy1, w_xfer, w_pad_wr, w_wr;
  logic [DATA_WIDTH-1:0]    w_wr_data;

  assign w_q0    = bus.req0_valid && !bus.req0_last;
  assign w_q1    = bus.req1_valid && !bus.req1_last;
  assign w_pick1 = w_q1 && (!w_q0 || r_ptr);

  assign w_g_valid = r_grant[1] ? bus.req1_valid : bus.req0_valid;
  assign w_g_last  = r_grant[1] ? bus.req1_last  : bus.req0_last;
  assign w_g_data  = r_grant[1] ? bus.req1_data  : bus.req0_data;

  always_comb begin
    w_rdy0   = 1'b0;
    w_rdy1   = 1'b0;
    w_g_rdy  = 1'b0;
    w_xfer   = 1'b0;
    w_pad_wr = 1'b0;
    case (r_state)
      S_IDLE: begin
        // stray beat1 outside a pair is swallowed so the producer cannot wedge
        w_rdy0 = bus.req0_valid && bus.req0_last;
        w_rdy1 = bus.req1_valid && bus.req1_last;
      end
      S_BEAT0: w_g_rdy = w_g_valid && !w_g_last && !bus.fifo_full;
      S_BEAT1: w_g_rdy = w_g_valid &&  w_g_last && !bus.fifo_full;
      S_PAD:   w_pad_wr = !bus.fifo_full;
      default: ;
    endcase
    if (r_state == S_BEAT0 || r_state == S_BEAT1) begin
      w_rdy0 = w_g_rdy && r_grant[0];
      w_rdy1 = w_g_rdy && r_grant[1];
      w_xfer = w_g_rdy;
    end
  end

  assign w_wr      = w_xfer || w_pad_wr;
  assign w_wr_data = w_pad_wr ? '0 : w_g_data;

  // ready is forced low while reset is held, even for the IDLE drop path
  assign bus.req0_ready   = rstn && w_rdy0;
  assign bus.req1_ready   = rstn && w_rdy1;
  assign bus.fifo_wr      = w_wr;
  assign bus.fifo_data_in = w_wr ? w_wr_data : r_data;
  assign grant            = r_grant;
  assign pad_event        = w_pad_wr;
  assign pad_count        = r_pad_cnt;
  assign proto_err        = r_perr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_grant   <= 2'b00;
      r_ptr     <= 1'b0;
      r_to      <= '0;
      r_pad_cnt <= '0;
      r_perr    <= 1'b0;
      r_data    <= '0;
    end else begin
      if (w_wr) r_data <= w_wr_data;
      case (r_state)
        S_IDLE: begin
          if (w_rdy0 || w_rdy1) r_perr <= 1'b1;
          if (en && !bus.fifo_threshold && (w_q0 || w_q1)) begin
            r_grant <= w_pick1 ? 2'b10 : 2'b01;
            r_state <= S_BEAT0;
          end
        end
        S_BEAT0: begin
          if (w_xfer) begin
            r_state <= S_BEAT1;
            r_to    <= '0;
          end
        end
        S_BEAT1: begin
          if (w_xfer) begin
            r_state <= S_IDLE;
            r_grant <= 2'b00;
            r_ptr   <= r_grant[0];
          end else begin
            if (w_g_valid && !w_g_last) r_perr <= 1'b1;
            // full stalls are the FIFO's fault, not the producer's, so they do not age the pair
            if (!bus.fifo_full) begin
              r_to <= r_to + 1'b1;
              if (r_to == TO_W'(TIMEOUT - 1)) r_state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          if (!bus.fifo_full) begin
            if (r_pad_cnt != {PAD_CNT_WIDTH{1'b1}}) r_pad_cnt <= r_pad_cnt + 1'b1;
            r_state <= S_IDLE;
            r_grant <= 2'b00;
            r_ptr   <= r_grant[0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_datapath_fifo_wr_arbiter.sv
// tb/tb_datapath_fifo_wr_arbiter.sv - directed vector bench for datapath_fifo_wr_arbiter
module tb_datapath_fifo_wr_arbiter;
  localparam int DW = 128;
  localparam int TO = 4;
  localparam int PW = 2;

  localparam logic [127:0] Z  = '0;
  localparam logic [127:0] A  = {16{8'h11}};
  localparam logic [127:0] B  = {16{8'h22}};
  localparam logic [127:0] C0 = {4{32'hC000_0000}};
  localparam logic [127:0] C1 = {4{32'hC000_0001}};
  localparam logic [127:0] C2 = {4{32'hC000_0002}};
  localparam logic [127:0] C3 = {4{32'hC000_0003}};
  localparam logic [127:0] D0 = {4{32'hD000_0000}};
  localparam logic [127:0] D1 = {4{32'hD000_0001}};
  localparam logic [127:0] D2 = {4{32'hD000_0002}};
  localparam logic [127:0] D3 = {4{32'hD000_0003}};
  localparam logic [127:0] E0 = {4{32'hE000_0000}};
  localparam logic [127:0] E1 = {4{32'hE000_0001}};
  localparam logic [127:0] F0 = {4{32'hF000_0000}};
  localparam logic [127:0] F1 = {4{32'hF000_0001}};
  localparam logic [127:0] S  = {4{32'h5555_AAAA}};
  localparam logic [127:0] P0 = {4{32'h0A0A_0000}};
  localparam logic [127:0] Q0 = {4{32'h0B0B_0000}};
  localparam logic [127:0] Q1 = {4{32'h0B0B_0001}};
  localparam logic [127:0] J0 = {4{32'h0C0C_0000}};
  localparam logic [127:0] J1 = {4{32'h0C0C_0001}};
  localparam logic [127:0] K0 = {4{32'h0D0D_0000}};
  localparam logic [127:0] K1 = {4{32'h0D0D_0001}};
  localparam logic [127:0] L0 = {4{32'h0E0E_0000}};
  localparam logic [127:0] L1 = {4{32'h0E0E_0001}};
  localparam logic [127:0] L2 = {4{32'h0E0E_0002}};
  localparam logic [127:0] M0 = {4{32'h0F0F_0000}};
  localparam logic [127:0] M1 = {4{32'h0F0F_0001}};

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    grant;
  logic          pad_event;
  logic [PW-1:0] pad_count;
  logic          proto_err;
  bit            en_n = 1'b1, thr_n = 1'b0, full_n = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;

  datapath_fifo_wr_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  datapath_fifo_wr_arbiter #(
    .DATA_WIDTH(DW), .TIMEOUT(TO), .PAD_CNT_WIDTH(PW)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .bus(bus),
    .grant(grant), .pad_event(pad_event), .pad_count(pad_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, en, thr, full;
    bit v0, l0; logic [127:0] d0;
    bit v1, l1; logic [127:0] d1;
    logic [1:0] g; bit r0, r1, wr; logic [127:0] din; bit pe, perr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(input bit rst, en_i, thr, full, v0, l0, input logic [127:0] d0,
                             input bit v1, l1, input logic [127:0] d1, input logic [1:0] g,
                             input bit r0, r1, wr, input logic [127:0] din, input bit pe, perr);
    vec_t t;
    t.rst = rst; t.en = en_i; t.thr = thr; t.full = full;
    t.v0 = v0; t.l0 = l0; t.d0 = d0; t.v1 = v1; t.l1 = l1; t.d1 = d1;
    t.g = g; t.r0 = r0; t.r1 = r1; t.wr = wr; t.din = din; t.pe = pe; t.perr = perr;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v0, l0, input logic [127:0] d0, input bit v1, l1, input logic [127:0] d1);
    @(negedge clk);
    en = en_n; bus.fifo_threshold = thr_n; bus.fifo_full = full_n;
    bus.req0_valid = v0; bus.req0_last = l0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_last = l1; bus.req1_data = d1;
    #1;
  endtask

  // lone requester w sends beat0 and stalls; pad follows TO cycles later, then the other side wins
  task automatic pad_pair(input bit w, input logic [1:0] exp_cnt);
    logic [1:0] gw, go;
    gw = w ? 2'b10 : 2'b01;
    go = w ? 2'b01 : 2'b10;
    if (w) drive(0, 0, Z, 1, 0, P0); else drive(1, 0, P0, 0, 0, Z);
    chk("pad idle grant", grant, 2'b00);
    if (w) drive(0, 0, Z, 1, 0, P0); else drive(1, 0, P0, 0, 0, Z);
    chk("pad beat0 grant", grant, gw);
    chk("pad beat0 wr", bus.fifo_wr, 1'b1);
    chk("pad beat0 data", bus.fifo_data_in, P0);
    for (int k = 0; k < TO; k++) begin
      drive(0, 0, Z, 0, 0, Z);
      chk("pad wait wr", bus.fifo_wr, 1'b0);
      chk("pad wait event", pad_event, 1'b0);
    end
    drive(1, 0, Q0, 1, 0, Q0);
    chk("pad wr", bus.fifo_wr, 1'b1);
    chk("pad data", bus.fifo_data_in, Z);
    chk("pad event", pad_event, 1'b1);
    chk("pad ready0", bus.req0_ready, 1'b0);
    chk("pad ready1", bus.req1_ready, 1'b0);
    drive(1, 0, Q0, 1, 0, Q0);
    chk("post pad grant", grant, 2'b00);
    chk("post pad count", pad_count, exp_cnt);
    chk("post pad event", pad_event, 1'b0);
    drive(1, 0, Q0, 1, 0, Q0);
    chk("post pad next grant", grant, go);
    chk("post pad next data", bus.fifo_data_in, Q0);
    if (w) drive(1, 1, Q1, 1, 0, Q0); else drive(1, 0, Q0, 1, 1, Q1);
    chk("post pad beat1 wr", bus.fifo_wr, 1'b1);
    chk("post pad beat1 data", bus.fifo_data_in, Q1);
    drive(0, 0, Z, 0, 0, Z);
    chk("post pad idle", grant, 2'b00);
  endtask

  initial begin
    bus.req0_valid = 0; bus.req0_last = 0; bus.req0_data = '0;
    bus.req1_valid = 0; bus.req1_last = 0; bus.req1_data = '0;
    bus.fifo_full = 0; bus.fifo_threshold = 0;

    // single pair from reset
    tbl.push_back(V(1,1,0,0, 0,0,Z,  0,0,Z,  2'b00,0,0,0,Z, 0,0));
    tbl.push_back(V(0,1,0,0, 1,0,A,  0,0,Z,  2'b00,0,0,0,Z, 0,0));
    tbl.push_back(V(0,1,0,0, 1,0,A,  0,0,Z,  2'b01,1,0,1,A, 0,0));
    tbl.push_back(V(0,1,0,0, 1,1,B,  0,0,Z,  2'b01,1,0,1,B, 0,0));
    tbl.push_back(V(0,1,0,0, 0,0,Z,  0,0,Z,  2'b00,0,0,0,B, 0,0));
    // both requesters streaming pairs, round robin from req0
    tbl.push_back(V(1,1,0,0, 0,0,Z,  0,0,Z,  2'b00,0,0,0,Z, 0,0));
    tbl.push_back(V(0,1,0,0, 1,0,C0, 1,0,D0, 2'b00,0,0,0,Z, 0,0));
    tbl.push_back(V(0,1,0,0, 1,0,C0, 1,0,D0, 2'b01,1,0,1,C0,0,0));
    tbl.push_back(V(0,1,0,0, 1,1,C1, 1,0,D0, 2'b01,1,0,1,C1,0,0));
    tbl.push_back(V(0,1,0,0, 1,0,C2, 1,0,D0, 2'b00,0,0,0,C1,0,0));
    tbl.push_back(V(0,1,0,0, 1,0,C2, 1,0,D0, 2'b10,0,1,1,D0,0,0));
    tbl.push_back(V(0,1,0,0, 1,0,C2, 1,1,D1, 2'b10,0,1,1,D1,0,0));
    tbl.push_back(V(0,1,0,0, 1,0,C2, 1,0,D2, 2'b00,0,0,0,D1,0,0));
    tbl.push_back(V(0,1,0,0, 1,0,C2, 1,0,D2, 2'b01,1,0,1,C2,0,0));
    tbl.push_back(V(0,1,0,0, 1,1,C3, 1,0,D2, 2'b01,1,0,1,C3,0,0));
    tbl.push_back(V(0,1,0,0, 0,0,Z,  1,0,D2, 2'b00,0,0,0,C3,0,0));
    tbl.push_back(V(0,1,0,0, 0,0,Z,  1,0,D2, 2'b10,0,1,1,D2,0,0));
    tbl.push_back(V(0,1,0,0, 0,0,Z,  1,1,D3, 2'b10,0,1,1,D3,0,0));
    tbl.push_back(V(0,1,0,0, 0,0,Z,  0,0,Z,  2'b00,0,0,0,D3,0,0));
    // threshold and enable hold-off in IDLE, ignored mid-pair
    tbl.push_back(V(0,1,1,0, 1,0,E0, 0,0,Z,  2'b00,0,0,0,D3,0,0));
    tbl.push_back(V(0,1,1,0, 1,0,E0, 0,0,Z,  2'b00,0,0,0,D3,0,0));
    tbl.push_back(V(0,1,0,0, 1,0,E0, 0,0,Z,  2'b00,0,0,0,D3,0,0));
    tbl.push_back(V(0,1,1,0, 1,0,E0, 0,0,Z,  2'b01,1,0,1,E0,0,0));
    tbl.push_back(V(0,1,1,0, 1,1,E1, 0,0,Z,  2'b01,1,0,1,E1,0,0));
    tbl.push_back(V(0,1,1,0, 0,0,Z,  0,0,Z,  2'b00,0,0,0,E1,0,0));
    tbl.push_back(V(0,0,0,0, 1,0,F0, 0,0,Z,  2'b00,0,0,0,E1,0,0));
    tbl.push_back(V(0,1,0,0, 1,0,F0, 0,0,Z,  2'b00,0,0,0,E1,0,0));
    tbl.push_back(V(0,0,0,0, 1,0,F0, 0,0,Z,  2'b01,1,0,1,F0,0,0));
    tbl.push_back(V(0,0,0,0, 1,1,F1, 0,0,Z,  2'b01,1,0,1,F1,0,0));
    tbl.push_back(V(0,1,0,0, 0,0,Z,  0,0,Z,  2'b00,0,0,0,F1,0,0));
    // stray last in IDLE is dropped and flags an error until reset
    tbl.push_back(V(1,1,0,0, 0,0,Z,  0,0,Z,  2'b00,0,0,0,Z, 0,0));
    tbl.push_back(V(0,1,0,0, 0,0,Z,  1,1,S,  2'b00,0,1,0,Z, 0,0));
    tbl.push_back(V(0,1,0,0, 0,0,Z,  0,0,Z,  2'b00,0,0,0,Z, 0,1));
    tbl.push_back(V(1,1,0,0, 0,0,Z,  0,0,Z,  2'b00,0,0,0,Z, 0,0));
    tbl.push_back(V(0,1,0,0, 0,0,Z,  0,0,Z,  2'b00,0,0,0,Z, 0,0));

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rstn = !tbl[i].rst; en = tbl[i].en;
      bus.fifo_threshold = tbl[i].thr; bus.fifo_full = tbl[i].full;
      bus.req0_valid = tbl[i].v0; bus.req0_last = tbl[i].l0; bus.req0_data = tbl[i].d0;
      bus.req1_valid = tbl[i].v1; bus.req1_last = tbl[i].l1; bus.req1_data = tbl[i].d1;
      #1;
      chk($sformatf("row%0d grant", i), grant, tbl[i].g);
      chk($sformatf("row%0d ready0", i), bus.req0_ready, tbl[i].r0);
      chk($sformatf("row%0d ready1", i), bus.req1_ready, tbl[i].r1);
      chk($sformatf("row%0d fifo_wr", i), bus.fifo_wr, tbl[i].wr);
      chk($sformatf("row%0d fifo_data_in", i), bus.fifo_data_in, tbl[i].din);
      chk($sformatf("row%0d pad_event", i), pad_event, tbl[i].pe);
      chk($sformatf("row%0d proto_err", i), proto_err, tbl[i].perr);
    end

    // full stalls longer than TIMEOUT in BEAT1 must not pad
    drive(1, 0, J0, 0, 0, Z);
    chk("stall idle grant", grant, 2'b00);
    drive(1, 0, J0, 0, 0, Z);
    chk("stall beat0 data", bus.fifo_data_in, J0);
    full_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, J1, 0, 0, Z);
      chk("stall wr", bus.fifo_wr, 1'b0);
      chk("stall ready0", bus.req0_ready, 1'b0);
      chk("stall event", pad_event, 1'b0);
    end
    full_n = 1'b0;
    drive(1, 1, J1, 0, 0, Z);
    chk("stall beat1 wr", bus.fifo_wr, 1'b1);
    chk("stall beat1 data", bus.fifo_data_in, J1);
    chk("stall beat1 event", pad_event, 1'b0);
    drive(0, 0, Z, 0, 0, Z);
    chk("stall pad_count", pad_count, 2'd0);

    // timeout pads, counter saturating at 3
    pad_pair(1'b1, 2'd1);
    pad_pair(1'b0, 2'd2);
    pad_pair(1'b1, 2'd3);
    pad_pair(1'b0, 2'd3);

    // asynchronous reset in the middle of BEAT1
    drive(1, 0, K0, 0, 0, Z);
    drive(1, 0, K0, 0, 0, Z);
    chk("rst pair grant", grant, 2'b01);
    full_n = 1'b1;
    drive(1, 1, K1, 0, 0, Z);
    chk("rst beat1 held", bus.fifo_wr, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("rst grant", grant, 2'b00);
    chk("rst fifo_wr", bus.fifo_wr, 1'b0);
    chk("rst ready0", bus.req0_ready, 1'b0);
    chk("rst pad_count", pad_count, 2'd0);
    chk("rst data", bus.fifo_data_in, Z);
    full_n = 1'b0;
    drive(0, 0, Z, 0, 0, Z);
    rstn = 1'b1;
    drive(1, 0, L0, 1, 0, M0);
    chk("fresh idle grant", grant, 2'b00);
    drive(1, 0, L0, 1, 0, M0);
    chk("fresh grant req0", grant, 2'b01);
    chk("fresh beat0 data", bus.fifo_data_in, L0);
    drive(1, 0, L2, 1, 0, M0);
    chk("bad beat1 ready0", bus.req0_ready, 1'b0);
    chk("bad beat1 wr", bus.fifo_wr, 1'b0);
    chk("bad beat1 perr before", proto_err, 1'b0);
    drive(1, 1, L1, 1, 0, M0);
    chk("good beat1 data", bus.fifo_data_in, L1);
    chk("bad beat1 perr", proto_err, 1'b1);
    drive(0, 0, Z, 1, 0, M0);
    chk("fresh idle2", grant, 2'b00);
    drive(0, 0, Z, 1, 0, M0);
    chk("fresh grant req1", grant, 2'b10);
    chk("fresh req1 data", bus.fifo_data_in, M0);
    drive(0, 0, Z, 1, 1, M1);
    chk("fresh req1 beat1", bus.fifo_data_in, M1);
    drive(0, 0, Z, 0, 0, Z);
    chk("final idle", grant, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
